// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types and default constants for the coin lane scheduler
package coin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_TRAVEL    = 3'd2,
        ST_WINDOW    = 3'd3,
        ST_GAME_OVER = 3'd4
    } sched_state_t;

    typedef logic [1:0] lane_idx_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    localparam int          DEF_N_LANES               = 3;
    localparam int          DEF_SPAWN_GAP_FRAMES      = 30;
    localparam int          DEF_TRAVEL_TIMEOUT_FRAMES = 64;
    localparam int          DEF_HIT_WINDOW_FRAMES     = 20;
    localparam int          DEF_MAX_MISSES            = 5;
    localparam int          DEF_SCORE_W               = 16;
    localparam logic [15:0] DEF_LFSR_SEED             = 16'hACE1;

endpackage

// File: rtl/vsync_tick.sv
// rtl/vsync_tick.sv - vsync synchronizer with a one-clock rising-edge frame tick
module vsync_tick (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_v_sync,
    output logic o_tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    // two flops for metastability, third flop remembers the previous level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= i_v_sync;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign o_tick = sync2 & ~sync3;

endmodule

// File: rtl/coin_scheduler.sv
// rtl/coin_scheduler.sv - spawns one coin at a time on a pseudo-random lane and scores hits and misses
module coin_scheduler
    import coin_pkg::*;
#(
    parameter int          N_LANES               = DEF_N_LANES,
    parameter int          SPAWN_GAP_FRAMES      = DEF_SPAWN_GAP_FRAMES,
    parameter int          TRAVEL_TIMEOUT_FRAMES = DEF_TRAVEL_TIMEOUT_FRAMES,
    parameter int          HIT_WINDOW_FRAMES     = DEF_HIT_WINDOW_FRAMES,
    parameter int          MAX_MISSES            = DEF_MAX_MISSES,
    parameter int          SCORE_W               = DEF_SCORE_W,
    parameter logic [15:0] LFSR_SEED             = DEF_LFSR_SEED
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_v_sync,
    input  logic               i_start,
    input  logic [N_LANES-1:0] i_in_position,
    input  logic [N_LANES-1:0] i_hit,
    output logic [N_LANES-1:0] o_active,
    output logic [1:0]         o_lane,
    output logic [SCORE_W-1:0] o_score,
    output logic [3:0]         o_misses,
    output logic               o_game_over,
    output logic               o_busy
);

    localparam logic [7:0] SPAWN_CNT    = 8'(SPAWN_GAP_FRAMES);
    localparam logic [7:0] TRAVEL_CNT   = 8'(TRAVEL_TIMEOUT_FRAMES);
    localparam logic [7:0] WINDOW_CNT   = 8'(HIT_WINDOW_FRAMES);
    localparam logic [3:0] MAX_MISS_CNT = 4'(MAX_MISSES);
    localparam logic [2:0] N_LANES_W    = 3'(N_LANES);
    localparam lane_idx_t  N_LANES_LO   = N_LANES_W[1:0];

    sched_state_t       state;
    logic [7:0]         frame_cnt;
    logic [15:0]        lfsr;
    logic               tick;
    logic               cnt_last;
    lane_idx_t          lane_pick;
    logic [N_LANES-1:0] pick_onehot;
    logic               sel_in_pos;
    logic               sel_hit;
    logic [3:0]         miss_next;

    vsync_tick u_vsync_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_v_sync (i_v_sync),
        .o_tick   (tick)
    );

    // free-running lane randomizer, advances every clock so the pick depends on start timing
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAP_MASK)};
        end
    end

    // fold out-of-range picks back into the legal lane range and build the one-hot enable
    always_comb begin
        pick_onehot = '0;
        if ({1'b0, lfsr[1:0]} >= N_LANES_W) begin
            lane_pick = lfsr[1:0] - N_LANES_LO;
        end else begin
            lane_pick = lfsr[1:0];
        end
        for (int i = 0; i < N_LANES; i++) begin
            pick_onehot[i] = (lane_pick == lane_idx_t'(i));
        end
    end

    // o_active is one-hot on o_lane while a coin is live, so masking with it selects that lane
    assign sel_in_pos  = |(i_in_position & o_active);
    assign sel_hit     = |(i_hit & o_active);
    assign cnt_last    = (frame_cnt == 8'd1);
    assign miss_next   = o_misses + 4'd1;
    assign o_game_over = (state == ST_GAME_OVER);
    assign o_busy      = (state == ST_GAP) || (state == ST_TRAVEL) || (state == ST_WINDOW);

    // spawn / travel / hit-window sequencer; a hit outranks an expiry in the same cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            o_active  <= '0;
            o_lane    <= '0;
            o_score   <= '0;
            o_misses  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (i_start) begin
                        state     <= ST_GAP;
                        frame_cnt <= SPAWN_CNT;
                        o_score   <= '0;
                        o_misses  <= '0;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (cnt_last) begin
                            state     <= ST_TRAVEL;
                            frame_cnt <= TRAVEL_CNT;
                            o_lane    <= lane_pick;
                            o_active  <= pick_onehot;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end
                end
                ST_TRAVEL, ST_WINDOW: begin
                    if ((state == ST_WINDOW) && sel_hit) begin
                        if (o_score != '1) begin
                            o_score <= o_score + 1'b1;
                        end
                        state     <= ST_GAP;
                        frame_cnt <= SPAWN_CNT;
                        o_active  <= '0;
                    end else if ((state == ST_TRAVEL) && sel_in_pos) begin
                        state     <= ST_WINDOW;
                        frame_cnt <= WINDOW_CNT;
                    end else if (tick && cnt_last) begin
                        o_misses <= miss_next;
                        o_active <= '0;
                        if (miss_next == MAX_MISS_CNT) begin
                            state <= ST_GAME_OVER;
                        end else begin
                            state     <= ST_GAP;
                            frame_cnt <= SPAWN_CNT;
                        end
                    end else if (tick) begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_active <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_scheduler.sv
// tb/tb_coin_scheduler.sv - table-driven frame-level bench for coin_scheduler
module tb_coin_scheduler;

    localparam int SPAWN  = 2;
    localparam int TRAVEL = 4;
    localparam int HITWIN = 3;
    localparam int MAXM   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_sync;
    logic        start;
    logic [2:0]  in_position;
    logic [2:0]  hit;
    logic [2:0]  active;
    logic [1:0]  lane;
    logic [15:0] score;
    logic [3:0]  misses;
    logic        game_over;
    logic        busy;

    coin_scheduler #(
        .N_LANES               (3),
        .SPAWN_GAP_FRAMES      (SPAWN),
        .TRAVEL_TIMEOUT_FRAMES (TRAVEL),
        .HIT_WINDOW_FRAMES     (HITWIN),
        .MAX_MISSES            (MAXM),
        .SCORE_W               (16),
        .LFSR_SEED             (16'hACE1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_v_sync      (v_sync),
        .i_start       (start),
        .i_in_position (in_position),
        .i_hit         (hit),
        .o_active      (active),
        .o_lane        (lane),
        .o_score       (score),
        .o_misses      (misses),
        .o_game_over   (game_over),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset to the seed
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        bit start;
        bit inpos;
        int hitm;      // 0 none, 1 selected lane in the tick cycle, 2 other lanes all frame
        bit spawn;
        bit post_hit;
        bit e_busy;
        bit e_go;
        int e_score;
        int e_miss;
        bit e_act;
    } vec_t;

    vec_t       tbl [48];
    int         n_rows = 0;
    int         n_vec  = 0;
    int         n_err  = 0;
    logic [1:0] exp_lane = 2'd0;

    function automatic logic [2:0] oh(input logic [1:0] l);
        return 3'b001 << l;
    endfunction

    function automatic logic [1:0] pick(input logic [15:0] s);
        logic [1:0] p;
        p = s[1:0];
        if (p == 2'd3) p = 2'd0;
        return p;
    endfunction

    task automatic add(input bit st, input bit ip, input int hm, input bit sp, input bit ph,
                       input bit eb, input bit eg, input int es, input int em, input bit ea);
        tbl[n_rows] = '{st, ip, hm, sp, ph, eb, eg, es, em, ea};
        n_rows++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rest(input string tag);
        chk({tag, " active"}, int'(active), 0);
        chk({tag, " lane"}, int'(lane), 0);
        chk({tag, " score"}, int'(score), 0);
        chk({tag, " misses"}, int'(misses), 0);
        chk({tag, " game_over"}, int'(game_over), 0);
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    // one selected-lane hit pulse outside the tick cycle; coin must drop on the very next clock
    task automatic hit_now(input int idx, input int e_score);
        hit = oh(exp_lane);
        @(negedge clk);
        hit = 3'b000;
        chk($sformatf("hit%0d active_drop", idx), int'(active), 0);
        chk($sformatf("hit%0d score", idx), int'(score), e_score);
        chk($sformatf("hit%0d busy", idx), int'(busy), 1);
    endtask

    // one 100-clock frame; vsync rises at k=0 so the scheduler's tick lands in the k=2 cycle
    task automatic run_row(input int idx);
        vec_t v;
        v = tbl[idx];
        for (int k = 0; k < 100; k++) begin
            if (k == 2 && v.spawn) exp_lane = pick(m_lfsr);
            start       = (k == 0) ? v.start : 1'b0;
            v_sync      = (k < 50);
            in_position = v.inpos ? oh(exp_lane) : 3'b000;
            case (v.hitm)
                1:       hit = (k == 2) ? oh(exp_lane) : 3'b000;
                2:       hit = ~oh(exp_lane);
                default: hit = 3'b000;
            endcase
            @(negedge clk);
        end
        chk($sformatf("r%0d busy", idx), int'(busy), int'(v.e_busy));
        chk($sformatf("r%0d game_over", idx), int'(game_over), int'(v.e_go));
        chk($sformatf("r%0d score", idx), int'(score), v.e_score);
        chk($sformatf("r%0d misses", idx), int'(misses), v.e_miss);
        chk($sformatf("r%0d active", idx), int'(active), v.e_act ? int'(oh(exp_lane)) : 0);
        if (v.e_act) chk($sformatf("r%0d lane", idx), int'(lane), int'(exp_lane));
        if (v.post_hit) hit_now(idx, v.e_score + 1);
    endtask

    initial begin
        if (SPAWN < 1 || SPAWN > 255 || TRAVEL < 1 || TRAVEL > 255 || HITWIN < 1 || HITWIN > 255) begin
            $display("FAIL frame parameter out of 1..255");
            $fatal(1, "bad parameters");
        end

        //   st ip hm sp ph | busy go score miss act
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // r0-9 idle
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); // r10 start
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 1); // r11 spawn
        add(0, 1, 0, 0, 1, 1, 0, 0, 0, 1); // r12 window, then hit
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0); // r13 gap
        add(0, 0, 0, 1, 0, 1, 0, 1, 0, 1); // r14 spawn two ticks after hit
        add(0, 1, 0, 0, 0, 1, 0, 1, 0, 1); // r15 window 3->2
        add(0, 1, 0, 0, 0, 1, 0, 1, 0, 1); // r16 2->1
        add(0, 1, 0, 0, 0, 1, 0, 1, 1, 0); // r17 window expiry miss
        add(1, 0, 0, 0, 0, 1, 0, 1, 1, 0); // r18 start ignored in gap
        add(0, 0, 0, 1, 0, 1, 0, 1, 1, 1); // r19 spawn
        add(0, 1, 0, 0, 0, 1, 0, 1, 1, 1); // r20
        add(0, 1, 0, 0, 0, 1, 0, 1, 1, 1); // r21
        add(0, 1, 0, 0, 0, 0, 1, 1, 2, 0); // r22 second miss -> game over
        add(0, 0, 0, 0, 0, 0, 1, 1, 2, 0); // r23 game over holds
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); // r24 restart clears
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 1); // r25 spawn, travel=4
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1); // r26 start ignored in travel
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); // r27
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); // r28
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); // r29 travel timeout on 4th tick
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); // r30
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 1); // r31 spawn
        add(0, 1, 2, 0, 0, 1, 0, 0, 1, 1); // r32 other-lane hits ignored
        add(0, 1, 2, 0, 0, 1, 0, 0, 1, 1); // r33
        add(0, 1, 1, 0, 0, 1, 0, 1, 1, 0); // r34 hit on expiry tick counts as hit
        add(0, 0, 0, 0, 0, 1, 0, 1, 1, 0); // r35
        add(0, 0, 0, 1, 0, 1, 0, 1, 1, 1); // r36 spawn
        add(0, 1, 0, 0, 1, 1, 0, 1, 1, 1); // r37 window, then hit
        add(0, 0, 0, 0, 0, 1, 0, 2, 1, 0); // r38
        add(0, 0, 0, 1, 0, 1, 0, 2, 1, 1); // r39 spawn
        add(0, 1, 0, 0, 1, 1, 0, 2, 1, 1); // r40 window, then hit
        add(0, 0, 0, 0, 0, 1, 0, 3, 1, 0); // r41
        add(0, 0, 0, 1, 0, 1, 0, 3, 1, 1); // r42 spawn
        add(0, 1, 0, 0, 0, 1, 0, 3, 1, 1); // r43 window with score 3

        rst_n = 1'b0; v_sync = 1'b0; start = 1'b0; in_position = 3'b000; hit = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        check_rest("reset");
        for (int i = 0; i < n_rows; i++) run_row(i);

        // one-clock reset while a coin is in its hit window
        rst_n = 1'b0; v_sync = 1'b0; start = 1'b0; in_position = 3'b000; hit = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        check_rest("midreset");

        // same start-to-spawn timing as the first run, so the same lanes must come out
        for (int i = 0; i <= 14; i++) begin
            run_row(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
